// File: rtl/selfcal_pkg.sv
// selfcal_pkg: shared definitions for the MBTRAIN self-calibration handshake.
// Holds the 3-bit state encoding and the sideband message codes used by the
// responder (selfcal_rx) and, later, the initiator.
package selfcal_pkg;

    typedef logic [2:0] state_t;
    typedef logic [3:0] sb_msg_t;

    localparam state_t ST_IDLE          = 3'd0;
    localparam state_t ST_CAL_ALGO      = 3'd1;
    localparam state_t ST_WAIT_REQ      = 3'd2;
    localparam state_t ST_SEND_RESP     = 3'd3;
    localparam state_t ST_TEST_FINISHED = 3'd4;
    localparam state_t ST_TIMEOUT       = 3'd5;

    localparam sb_msg_t SB_NONE             = 4'b0000;
    localparam sb_msg_t SB_SELFCAL_END_REQ  = 4'b0001;
    localparam sb_msg_t SB_SELFCAL_END_RESP = 4'b0010;

endpackage

// File: rtl/selfcal_rx_if.sv
// selfcal_rx_if: sideband bundle between the self-cal responder and the
// sideband RX decoder / shared TX mux.
//   i_sideband_valid, i_decoded_sideband_message : received message + qualifier
//   i_busy_negedge_detected, i_valid_tx          : TX mux completion / contention
//   o_sideband_message, o_valid_rx               : message request to the TX mux
// Modports: slave = the responder block, master = the sideband side driving it.
interface selfcal_rx_if;
    import selfcal_pkg::*;

    logic    i_sideband_valid;
    sb_msg_t i_decoded_sideband_message;
    logic    i_busy_negedge_detected;
    logic    i_valid_tx;
    sb_msg_t o_sideband_message;
    logic    o_valid_rx;

    modport slave (
        input  i_sideband_valid,
        input  i_decoded_sideband_message,
        input  i_busy_negedge_detected,
        input  i_valid_tx,
        output o_sideband_message,
        output o_valid_rx
    );

    modport master (
        output i_sideband_valid,
        output i_decoded_sideband_message,
        output i_busy_negedge_detected,
        output i_valid_tx,
        input  o_sideband_message,
        input  o_valid_rx
    );

endinterface

// File: rtl/sb_wait_cnt.sv
// sb_wait_cnt: loadable up-counter with a terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val (priority over inc)
//   inc      : increment by one
//   tc       : count currently equals Terminal-1
module sb_wait_cnt #(
    parameter int unsigned Width    = 16,
    parameter int unsigned Terminal = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             inc,
    output logic             tc
);

    localparam logic [Width-1:0] TermVal = Width'(Terminal - 1);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (inc) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign tc = (cnt_q == TermVal);

endmodule

// File: rtl/selfcal_rx.sv
// selfcal_rx: responder side of the MBTRAIN self-calibration handshake.
// Runs a CAL_CYCLES local calibration window, accepts the partner's end-request,
// answers with an end-response via the shared sideband TX mux, then raises
// o_test_ack until the enable drops.
//   clk, rst    : clock, synchronous active-high reset
//   i_en        : substate enable; low forces IDLE and clears everything
//   sb          : sideband bundle (selfcal_rx_if.slave)
//   o_test_ack  : responder done
//   o_timeout   : sticky wait timeout (tied 0 unless SELFCAL_RX_TIMEOUT_EN)
// Optional feature macro: SELFCAL_RX_TIMEOUT_EN adds a TIMEOUT_CYCLES wait limit
// in WAIT_REQ/SEND_RESP.
module selfcal_rx
    import selfcal_pkg::*;
#(
    parameter int unsigned CAL_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    selfcal_rx_if.slave    sb,
    output logic           o_test_ack,
    output logic           o_timeout
);

    // One width serves both counters so the instances stay identical.
    localparam int unsigned MaxCnt = (CAL_CYCLES > TIMEOUT_CYCLES) ? CAL_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    state_t  state_q, state_d;
    logic    req_pend_q, req_pend_d;
    sb_msg_t msg_q, msg_d;
    logic    vld_q, vld_d;
    logic    ack_q, ack_d;
    logic    cal_load, cal_inc, cal_tc;
    logic    req;

    assign req = sb.i_sideband_valid && (sb.i_decoded_sideband_message == SB_SELFCAL_END_REQ);

    sb_wait_cnt #(
        .Width    (CntW),
        .Terminal (CAL_CYCLES)
    ) u_cal_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cal_load),
        .load_val ('0),
        .inc      (cal_inc),
        .tc       (cal_tc)
    );

`ifdef SELFCAL_RX_TIMEOUT_EN
    logic to_q, to_d;
    logic wt_load, wt_inc, wt_tc;

    sb_wait_cnt #(
        .Width    (CntW),
        .Terminal (TIMEOUT_CYCLES)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wt_load),
        .load_val ('0),
        .inc      (wt_inc),
        .tc       (wt_tc)
    );
`endif

    always_comb begin
        state_d    = state_q;
        req_pend_d = req_pend_q;
        msg_d      = msg_q;
        vld_d      = vld_q;
        ack_d      = ack_q;
        cal_load   = 1'b0;
        cal_inc    = 1'b0;
`ifdef SELFCAL_RX_TIMEOUT_EN
        to_d       = to_q;
        wt_load    = 1'b0;
        wt_inc     = 1'b0;
`endif
        if (!i_en) begin
            state_d    = ST_IDLE;
            req_pend_d = 1'b0;
            msg_d      = SB_NONE;
            vld_d      = 1'b0;
            ack_d      = 1'b0;
            cal_load   = 1'b1;
`ifdef SELFCAL_RX_TIMEOUT_EN
            to_d       = 1'b0;
            wt_load    = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_CAL_ALGO;
                    cal_load = 1'b1;
                end
                ST_CAL_ALGO: begin
                    cal_inc = 1'b1;
                    if (req) req_pend_d = 1'b1;
                    if (cal_tc) begin
`ifdef SELFCAL_RX_TIMEOUT_EN
                        wt_load = 1'b1;
`endif
                        // A request in the final window cycle counts as pending.
                        if (req_pend_q || req) begin
                            state_d = ST_SEND_RESP;
                            msg_d   = SB_SELFCAL_END_RESP;
                            vld_d   = 1'b1;
                        end else begin
                            state_d = ST_WAIT_REQ;
                        end
                    end
                end
                ST_WAIT_REQ: begin
`ifdef SELFCAL_RX_TIMEOUT_EN
                    wt_inc = 1'b1;
`endif
                    if (req) begin
                        state_d = ST_SEND_RESP;
                        msg_d   = SB_SELFCAL_END_RESP;
                        vld_d   = 1'b1;
`ifdef SELFCAL_RX_TIMEOUT_EN
                        wt_load = 1'b1;
                    end else if (wt_tc) begin
                        state_d = ST_TIMEOUT;
                        to_d    = 1'b1;
`endif
                    end
                end
                ST_SEND_RESP: begin
`ifdef SELFCAL_RX_TIMEOUT_EN
                    wt_inc = 1'b1;
`endif
                    // Another requester still owning the mux blocks the release.
                    if (sb.i_busy_negedge_detected && !sb.i_valid_tx) begin
                        state_d = ST_TEST_FINISHED;
                        msg_d   = SB_NONE;
                        vld_d   = 1'b0;
                        ack_d   = 1'b1;
`ifdef SELFCAL_RX_TIMEOUT_EN
                    end else if (wt_tc) begin
                        state_d = ST_TIMEOUT;
                        msg_d   = SB_NONE;
                        vld_d   = 1'b0;
                        to_d    = 1'b1;
`endif
                    end
                end
                ST_TEST_FINISHED: ;
`ifdef SELFCAL_RX_TIMEOUT_EN
                ST_TIMEOUT: ;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_pend_q <= 1'b0;
            msg_q      <= SB_NONE;
            vld_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pend_q <= req_pend_d;
            msg_q      <= msg_d;
            vld_q      <= vld_d;
            ack_q      <= ack_d;
        end
    end

`ifdef SELFCAL_RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= 1'b0;
        end else begin
            to_q <= to_d;
        end
    end
    assign o_timeout = to_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign sb.o_sideband_message = msg_q;
    assign sb.o_valid_rx         = vld_q;
    assign o_test_ack            = ack_q;

endmodule

// File: tb/tb_selfcal_rx.sv
// tb_selfcal_rx: randomized bench for selfcal_rx against an edge-counting
// reference model. Follows SELFCAL_RX_TIMEOUT_EN in the same way as the RTL.
module tb_selfcal_rx;

    localparam int unsigned CalCycles = 8;
    localparam int unsigned ToCycles  = 16;
`ifdef SELFCAL_RX_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic i_en;
    logic o_test_ack;
    logic o_timeout;

    selfcal_rx_if sb_if ();

    selfcal_rx #(
        .CAL_CYCLES     (CalCycles),
        .TIMEOUT_CYCLES (ToCycles)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .sb         (sb_if),
        .o_test_ack (o_test_ack),
        .o_timeout  (o_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: k counts enabled edges since the enable rose (edge 1 is
    // the IDLE edge). The response goes out at the later of the first request
    // edge and the last window edge (CalCycles+1); the release is the first
    // later edge with busy && !valid_tx.
    int k      = 0;
    int resp_k = 0;
    bit pend   = 1'b0;
    bit done   = 1'b0;
    bit to_f   = 1'b0;

    task automatic model_step(input bit r, input bit en, input bit req, input bit busy,
                              input bit vtx);
        if (r || !en) begin
            k = 0; resp_k = 0; pend = 1'b0; done = 1'b0; to_f = 1'b0;
        end else begin
            k++;
            if (resp_k == 0 && !to_f) begin
                if (k >= 2 && req) pend = 1'b1;
                if (pend && k >= int'(CalCycles) + 1) resp_k = k;
                else if (ToEn && k == int'(CalCycles + 1 + ToCycles)) to_f = 1'b1;
            end else if (resp_k != 0 && !done && !to_f) begin
                if (busy && !vtx) done = 1'b1;
                else if (ToEn && k == resp_k + int'(ToCycles)) to_f = 1'b1;
            end
        end
    endtask

    task automatic run_cycle(input bit r, input bit en, input bit sv, input logic [3:0] m,
                             input bit busy, input bit vtx);
        bit exp_vld;
        rst  = r;
        i_en = en;
        sb_if.i_sideband_valid           = sv;
        sb_if.i_decoded_sideband_message = m;
        sb_if.i_busy_negedge_detected    = busy;
        sb_if.i_valid_tx                 = vtx;
        @(posedge clk);
        model_step(r, en, sv && (m == 4'b0001), busy, vtx);
        #1;
        exp_vld = (resp_k != 0) && !done && !to_f;
        check_eq("valid_rx", 32'(sb_if.o_valid_rx), 32'(exp_vld));
        check_eq("sb_msg", 32'(sb_if.o_sideband_message), exp_vld ? 32'h2 : 32'h0);
        check_eq("test_ack", 32'(o_test_ack), 32'(done));
        check_eq("timeout", 32'(o_timeout), 32'(to_f));
    endtask

    // Per-mille probabilities: request, enable drop, busy negedge, valid_tx.
    int phase_cfg [4][4] = '{
        '{100, 5, 300, 500},
        '{15, 3, 200, 300},
        '{40, 4, 500, 800},
        '{60, 30, 400, 200}
    };

    initial begin
        int en_low;
        bit en, sv, busy, vtx;
        logic [3:0] m;

        // Reset with enable high and a stray request on the bus.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0);

        en_low = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 3000; c++) begin
                if (en_low > 0) begin
                    en_low--;
                    en = 1'b0;
                end else if ($urandom_range(999) < phase_cfg[p][1]) begin
                    en_low = $urandom_range(2);
                    en = 1'b0;
                end else begin
                    en = 1'b1;
                end
                if ($urandom_range(999) < phase_cfg[p][0]) begin
                    sv = 1'b1;
                    m  = 4'b0001;
                end else if ($urandom_range(1) == 0) begin
                    // Valid-low request: must be ignored.
                    sv = 1'b0;
                    m  = 4'(($urandom_range(1) == 0) ? 1 : $urandom_range(15));
                end else begin
                    sv = 1'b1;
                    m  = 4'($urandom_range(15));
                    if (m == 4'b0001) m = 4'b0011;
                end
                busy = ($urandom_range(999) < phase_cfg[p][2]);
                vtx  = ($urandom_range(999) < phase_cfg[p][3]);
                run_cycle(1'b0, en, sv, m, busy, vtx);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/selfcal_rx.md
# selfcal_rx

Responder side of the MBTRAIN self-calibration handshake. While enabled, it runs a fixed-length local calibration window and accepts the partner's end-request sideband message (4'b0001). It then answers with an end-response (4'b0010) through the shared sideband TX mux and raises a test-done acknowledge to the MBTRAIN controller. It is the counterpart of the initiator that issues the end-request and waits for this response.

## Interface
- CAL_CYCLES, 8: length of the local calibration window in clk cycles; legal range ≥1.
- TIMEOUT_CYCLES, 8000: wait limit in WAIT_REQ/SEND_RESP; used only when SELFCAL_RX_TIMEOUT_EN is defined.
- clk  input  1  block clock, all logic on rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- i_en  input  1  substate enable from MBTRAIN controller.
- i_sideband_valid  input  1  qualifies i_decoded_sideband_message.
- i_decoded_sideband_message  input  4  decoded received sideband message.
- i_busy_negedge_detected  input  1  sideband TX finished sending the current message.
- i_valid_tx  input  1  other requester on the shared mux still valid; blocks release.
- o_sideband_message  output  4  message to send: 4'b0010 end-response, else 4'b0000.
- o_valid_rx  output  1  request to the sideband mux for o_sideband_message.
- o_test_ack  output  1  self-calibration responder done.
- o_timeout  output  1  sticky wait-timeout flag; constant 0 without the macro.

## Operation
- States: IDLE, CAL_ALGO, WAIT_REQ, SEND_RESP, TEST_FINISHED, TIMEOUT. TIMEOUT exists only with the macro.
- Valid request: i_sideband_valid=1 and message==4'b0001. Every other value, and any message with valid low, is ignored.
- rst=1: state IDLE; all outputs, counters and req_pending cleared to 0.
- i_en=0 in any state: next edge forces IDLE and clears all outputs, counters and req_pending. This has priority over every other transition.
- IDLE: i_en=1 → CAL_ALGO; cal counter loads 0.
- CAL_ALGO:
  - Cal counter increments each cycle.
  - A valid request sets req_pending.
  - At the edge where counter==CAL_CYCLES-1: go to SEND_RESP if req_pending or a request is present this cycle, else WAIT_REQ.
- WAIT_REQ: valid request → SEND_RESP.
- Entry into SEND_RESP, on the same edge: o_sideband_message<=4'b0010, o_valid_rx<=1.
- SEND_RESP: when i_busy_negedge_detected=1 and i_valid_tx=0, on that edge:
  - o_valid_rx<=0 and o_sideband_message<=0;
  - o_test_ack<=1;
  - state → TEST_FINISHED.
- While i_valid_tx=1, busy negedges are ignored and the response is held.
- TEST_FINISHED: outputs held (o_test_ack=1) until i_en=0. Further requests are ignored.
- Repeated requests in SEND_RESP are ignored; only one response is sent per enable.

## Timing
- Reset values: o_sideband_message=0, o_valid_rx=0, o_test_ack=0, o_timeout=0.
- All outputs are registered; no combinational input→output path.
- Edge E0 samples i_en=1 in IDLE. If a request arrives at or before the final CAL_ALGO cycle, o_valid_rx rises after edge E0+CAL_CYCLES.
- Request sampled in WAIT_REQ at edge E → o_valid_rx=1 after E (1-cycle latency).
- Release qualifier sampled at edge E → o_valid_rx=0 and o_test_ack=1 after E.
- Request in the final CAL_ALGO cycle counts as pending; no extra WAIT_REQ cycle.
- i_en falling in the same cycle as the release qualifier: the i_en clear wins and o_test_ack stays 0.

## Configuration
- SELFCAL_RX_TIMEOUT_EN defined:
  - The wait counter clears on entry to WAIT_REQ and SEND_RESP and increments each cycle there.
  - Counter==TIMEOUT_CYCLES-1 without leaving the state → TIMEOUT: o_timeout<=1, o_valid_rx<=0, o_sideband_message<=0.
  - TIMEOUT is left only via i_en=0.
- Macro undefined: no wait counter and no TIMEOUT state; o_timeout is tied 0; the block waits indefinitely.

## Structure
- Shared package selfcal_pkg holds:
  - state encoding typedef (3 bits);
  - message constants SB_NONE=4'b0000, SB_SELFCAL_END_REQ=4'b0001, SB_SELFCAL_END_RESP=4'b0010.
- One sub-module, sb_wait_cnt: a loadable up-counter with a terminal-count flag, shared later with the initiator for timeouts. Used for both the cal window and the wait timeout.

## Test plan
- rst=1 with i_en=1 and stray messages → all outputs 0, state IDLE.
- CAL_CYCLES=8; request at cycle 3 of CAL_ALGO → o_valid_rx=1 and message 4'b0010 exactly 8 edges after the CAL_ALGO entry; a single response.
- No request during cal; request 20 cycles later → SEND_RESP one edge after sampling. Message 4'b0011 and requests with valid low never trigger a response.
- In SEND_RESP, busy negedge with i_valid_tx=1 → response held; next negedge with i_valid_tx=0 → o_valid_rx=0, o_test_ack=1, message 0.
- i_en dropped in SEND_RESP and in TEST_FINISHED → next edge all outputs 0, state IDLE; re-enable runs a full new cal window.
- With SELFCAL_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16, no request → o_timeout=1 after 16 WAIT_REQ cycles; a late request is ignored; i_en=0 clears it.
